// File: rtl/conv2d_unroll3.sv
// conv2d_unroll3: 3x3 convolution (9 unsigned 8-bit pixels times 9 unsigned
// 8-bit coefficients). Three parallel MAC lanes process one kernel row per
// cycle, so a result is ready three cycles after the operands are captured.
// Optional build macro CONV2D_UNROLL3_SAT_EN: when defined, a sum above 65535
// saturates to 16'hFFFF. When undefined, the result wraps modulo 2^16.
module conv2d_unroll3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic [7:0]  in4,
    input  logic [7:0]  in5,
    input  logic [7:0]  in6,
    input  logic [7:0]  in7,
    input  logic [7:0]  in8,
    input  logic [7:0]  k0,
    input  logic [7:0]  k1,
    input  logic [7:0]  k2,
    input  logic [7:0]  k3,
    input  logic [7:0]  k4,
    input  logic [7:0]  k5,
    input  logic [7:0]  k6,
    input  logic [7:0]  k7,
    input  logic [7:0]  k8,
    output logic [15:0] out,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW0 = 3'd1,
        S_ROW1 = 3'd2,
        S_ROW2 = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  in_q [9];
    logic [7:0]  k_q  [9];
    logic [19:0] acc_q, acc_d;
    logic [15:0] out_q, out_d;
    logic        done_q, done_d;
    logic        capture;

    // Lane operands for the row selected by the current state
    logic [7:0]  a0, a1, a2;
    logic [7:0]  b0, b1, b2;
    logic [15:0] p0, p1, p2;
    logic [17:0] row_sum;
    logic [19:0] acc_sum;

    // The 20-bit accumulator cannot overflow (9*255*255 < 2^20); only the
    // 16-bit output needs narrowing, either by saturation or by wrapping.
    function automatic logic [15:0] finalize(input logic [19:0] s);
`ifdef CONV2D_UNROLL3_SAT_EN
        return (s[19:16] != 4'd0) ? 16'hFFFF : s[15:0];
`else
        return s[15:0];
`endif
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers: snapshot of the window and kernel at the start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                in_q[i] <= 8'd0;
                k_q[i]  <= 8'd0;
            end
        end else if (capture) begin
            in_q[0] <= in0;
            in_q[1] <= in1;
            in_q[2] <= in2;
            in_q[3] <= in3;
            in_q[4] <= in4;
            in_q[5] <= in5;
            in_q[6] <= in6;
            in_q[7] <= in7;
            in_q[8] <= in8;
            k_q[0]  <= k0;
            k_q[1]  <= k1;
            k_q[2]  <= k2;
            k_q[3]  <= k3;
            k_q[4]  <= k4;
            k_q[5]  <= k5;
            k_q[6]  <= k6;
            k_q[7]  <= k7;
            k_q[8]  <= k8;
        end
    end

    // Row select and three parallel multiplies feeding one adder tree
    always_comb begin
        a0 = 8'd0;
        a1 = 8'd0;
        a2 = 8'd0;
        b0 = 8'd0;
        b1 = 8'd0;
        b2 = 8'd0;
        case (state_q)
            S_ROW0: begin
                a0 = in_q[0]; a1 = in_q[1]; a2 = in_q[2];
                b0 = k_q[0];  b1 = k_q[1];  b2 = k_q[2];
            end
            S_ROW1: begin
                a0 = in_q[3]; a1 = in_q[4]; a2 = in_q[5];
                b0 = k_q[3];  b1 = k_q[4];  b2 = k_q[5];
            end
            S_ROW2: begin
                a0 = in_q[6]; a1 = in_q[7]; a2 = in_q[8];
                b0 = k_q[6];  b1 = k_q[7];  b2 = k_q[8];
            end
            default: ;
        endcase
        p0      = a0 * b0;
        p1      = a1 * b1;
        p2      = a2 * b2;
        row_sum = 18'(p0) + 18'(p1) + 18'(p2);
        acc_sum = acc_q + 20'(row_sum);
    end

    // Next-state and datapath control; start is only honoured in IDLE/DONE
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        done_d  = done_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    capture = 1'b1;
                    acc_d   = 20'd0;
                    done_d  = 1'b0;
                    state_d = S_ROW0;
                end
            end
            S_ROW0: begin
                acc_d   = acc_sum;
                state_d = S_ROW1;
            end
            S_ROW1: begin
                acc_d   = acc_sum;
                state_d = S_ROW2;
            end
            S_ROW2: begin
                acc_d   = acc_sum;
                out_d   = finalize(acc_sum);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Accumulator, result and completion flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= 20'd0;
            out_q  <= 16'd0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: tb/tb_conv2d_unroll3.sv
// Self-checking bench for conv2d_unroll3: fixed vector table, hand-written
// multi-cycle sequences and randomized operands against a dot-product model.
module tb_conv2d_unroll3;

    logic             clk;
    logic             rst;
    logic             start;
    logic [8:0][7:0]  a_drv;
    logic [8:0][7:0]  b_drv;
    logic [15:0]      out;
    logic             done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [8:0][7:0] a;
        logic [8:0][7:0] b;
        logic [15:0]     exp;
    } vec_t;

    vec_t tbl [4];

    conv2d_unroll3 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in0   (a_drv[0]),
        .in1   (a_drv[1]),
        .in2   (a_drv[2]),
        .in3   (a_drv[3]),
        .in4   (a_drv[4]),
        .in5   (a_drv[5]),
        .in6   (a_drv[6]),
        .in7   (a_drv[7]),
        .in8   (a_drv[8]),
        .k0    (b_drv[0]),
        .k1    (b_drv[1]),
        .k2    (b_drv[2]),
        .k3    (b_drv[3]),
        .k4    (b_drv[4]),
        .k5    (b_drv[5]),
        .k6    (b_drv[6]),
        .k7    (b_drv[7]),
        .k8    (b_drv[8]),
        .out   (out),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain dot product over the first n elements
    function automatic int psum(input logic [8:0][7:0] a, input logic [8:0][7:0] b, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(a[i]) * int'(b[i]);
        return s;
    endfunction

    function automatic logic [15:0] model(input logic [8:0][7:0] a, input logic [8:0][7:0] b);
        int s;
        s = psum(a, b, 9);
`ifdef CONV2D_UNROLL3_SAT_EN
        if (s > 65535) return 16'hFFFF;
`endif
        return 16'(s);
    endfunction

    function automatic logic [8:0][7:0] fill(input logic [7:0] v);
        logic [8:0][7:0] r;
        for (int i = 0; i < 9; i++) r[i] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then check done stays low for two edges, rises on the third
    task automatic run_conv(input string name, input logic [8:0][7:0] a,
                            input logic [8:0][7:0] b, input logic [15:0] exp);
        a_drv = a;
        b_drv = b;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, " done low after capture"}, 32'(done), 32'd0);
        step();
        step();
        check({name, " done low at E+2"}, 32'(done), 32'd0);
        step();
        check({name, " done at E+3"}, 32'(done), 32'd1);
        check({name, " out"}, 32'(out), 32'(exp));
    endtask

    initial begin
        logic [8:0][7:0] ra, rb, seq, rev;
        rst   = 1'b0;
        start = 1'b0;
        a_drv = '0;
        b_drv = '0;

        for (int i = 0; i < 9; i++) begin
            seq[i] = 8'(i + 1);
            rev[i] = 8'(9 - i);
        end
        tbl[0] = '{a: fill(8'd1),   b: fill(8'd1),   exp: 16'd9};
        tbl[1] = '{a: seq,          b: rev,          exp: 16'd165};
`ifdef CONV2D_UNROLL3_SAT_EN
        tbl[2] = '{a: fill(8'd255), b: fill(8'd255), exp: 16'd65535};
`else
        tbl[2] = '{a: fill(8'd255), b: fill(8'd255), exp: 16'd60937};
`endif
        tbl[3] = '{a: fill(8'd2),   b: fill(8'd2),   exp: 16'd36};

        // Reset held for two cycles
        step();
        step();
        check("reset out", 32'(out), 32'd0);
        check("reset done", 32'(done), 32'd0);
        rst = 1'b1;
        step();
        check("idle done", 32'(done), 32'd0);

        // Table vectors
        for (int t = 0; t < 4; t++) begin
            run_conv($sformatf("tbl%0d", t), tbl[t].a, tbl[t].b, tbl[t].exp);
        end

        // Done and out hold in DONE
        run_conv("ones", fill(8'd1), fill(8'd1), 16'd9);
        step();
        step();
        check("ones done hold", 32'(done), 32'd1);
        check("ones out hold", 32'(out), 32'd9);

        // Row partial sums of the accumulator
        a_drv = seq;
        b_drv = rev;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("row0 partial", 32'(dut.acc_q), 32'(psum(seq, rev, 3)));
        step();
        check("row1 partial", 32'(dut.acc_q), 32'(psum(seq, rev, 6)));
        step();
        check("row2 partial", 32'(dut.acc_q), 32'(psum(seq, rev, 9)));
        check("row out", 32'(out), 32'd165);

        // Operands change after capture, start re-pulsed during ROW1
        a_drv = fill(8'd1);
        b_drv = fill(8'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a_drv = fill(8'd2);
        b_drv = fill(8'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign done E+2", 32'(done), 32'd0);
        step();
        check("ign done E+3", 32'(done), 32'd1);
        check("ign out", 32'(out), 32'd9);
        for (int i = 0; i < 4; i++) step();
        check("ign no rerun done", 32'(done), 32'd1);
        check("ign no rerun out", 32'(out), 32'd9);

        // Asynchronous reset during ROW1
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("async rst out", 32'(out), 32'd0);
        check("async rst done", 32'(done), 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("aborted no done", 32'(done), 32'd0);
        check("aborted out", 32'(out), 32'd0);
        run_conv("post rst", fill(8'd1), fill(8'd1), 16'd9);

        // Back-to-back with start held high
        a_drv = fill(8'd1);
        b_drv = fill(8'd1);
        start = 1'b1;
        step();
        a_drv = fill(8'd2);
        b_drv = fill(8'd2);
        step();
        step();
        check("b2b done low", 32'(done), 32'd0);
        step();
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first out", 32'(out), 32'd9);
        step();
        check("b2b done one cycle", 32'(done), 32'd0);
        step();
        step();
        check("b2b done low 2", 32'(done), 32'd0);
        step();
        start = 1'b0;
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second out", 32'(out), 32'd36);
        step();
        check("b2b stays done", 32'(done), 32'd1);

        // Randomized operands against the model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 9; i++) begin
                ra[i] = 8'($urandom_range(0, 255));
                rb[i] = 8'($urandom_range(0, 255));
            end
            if (r < 4) begin
                for (int i = 0; i < 9; i++) begin
                    ra[i] = 8'($urandom_range(200, 255));
                    rb[i] = 8'($urandom_range(200, 255));
                end
            end
            run_conv($sformatf("rand%0d", r), ra, rb, model(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
